watch_core: RTL and testbench

Parametrised time-of-day keeper and 8-digit display formatter, the next generation of the board's digital clock interface. All logic runs on the 100 MHz system clock and advances only on the one-cycle `pulse_1hz` enable. It adds rising-edge button detection with hold-to-repeat, a 12/24-hour display mode, an idle timeout out of set mode, a blinking separator and an optional alarm. It feeds the 8-digit display multiplexer directly.

---
 rtl/watch_core.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_watch_core.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/watch_core.sv
`default_nettype none
// ============================================================================
//  Module   : watch_core
//  Purpose  : Time-of-day keeper (hh:mm:ss, 24-hour storage) with button
//             driven set mode, hold-to-repeat, idle timeout back to RUN,
//             12/24-hour display mapping and an 8-digit display formatter.
//             Optional alarm feature enabled by defining WATCH_ALARM_EN.
//  Ports    : clock        - system clock (100 MHz)
//             reset        - asynchronous, active-high reset
//             pulse_1hz    - one-cycle enable, once per second
//             pulse_500ms  - 1 Hz square wave used for blinking
//             mode_button  - debounced level, steps the set-mode FSM
//             add_button   - debounced level, +1 on the edited field
//             sub_button   - debounced level, -1 on the edited field
//             mode_12h     - 1 = 12-hour display, 0 = 24-hour display
//             alarm_armed  - alarm enable            (WATCH_ALARM_EN only)
//             alarm_out    - alarm active            (WATCH_ALARM_EN only)
//             d1..d8       - digit words {en, bcd[3:0], dp_n}, d8 leftmost
//  Revision : 1.0 - initial release
// ============================================================================
module watch_core #(
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int SET_TIMEOUT_S = 30
`ifdef WATCH_ALARM_EN
    ,
    parameter int ALARM_SECONDS = 60
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pulse_1hz,
    input  logic       pulse_500ms,
    input  logic       mode_button,
    input  logic       add_button,
    input  logic       sub_button,
    input  logic       mode_12h,
`ifdef WATCH_ALARM_EN
    input  logic       alarm_armed,
    output logic       alarm_out,
`endif
    output logic [5:0] d1,
    output logic [5:0] d2,
    output logic [5:0] d3,
    output logic [5:0] d4,
    output logic [5:0] d5,
    output logic [5:0] d6,
    output logic [5:0] d7,
    output logic [5:0] d8
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_REP_W   = (c_REP_MAX > 1) ? $clog2(c_REP_MAX + 1) : 1;
    localparam logic [c_REP_W-1:0] c_DELAY  = c_REP_W'(REPEAT_DELAY);
    localparam logic [c_REP_W-1:0] c_PERIOD = c_REP_W'(REPEAT_PERIOD);

    localparam bit c_TIMEOUT_EN = (SET_TIMEOUT_S > 0);
    localparam int c_IDLE_W     = (SET_TIMEOUT_S > 1) ? $clog2(SET_TIMEOUT_S + 1) : 1;
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST =
        c_IDLE_W'((SET_TIMEOUT_S > 0) ? SET_TIMEOUT_S - 1 : 0);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_H    = 3'd1,
        ST_SET_M    = 3'd2,
        ST_SET_S    = 3'd3
`ifdef WATCH_ALARM_EN
        ,
        ST_SET_AH   = 3'd4,
        ST_SET_AM   = 3'd5
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [5:0] wrap_up(input logic [5:0] v, input logic [5:0] top);
        wrap_up = (v == top) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dn(input logic [5:0] v, input logic [5:0] top);
        wrap_dn = (v == 6'd0) ? top : v - 6'd1;
    endfunction

    // Binary 0..59 to two BCD digits {tens, units}
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] base;
        if (v >= 6'd50) begin
            t = 4'd5; base = 6'd50;
        end else if (v >= 6'd40) begin
            t = 4'd4; base = 6'd40;
        end else if (v >= 6'd30) begin
            t = 4'd3; base = 6'd30;
        end else if (v >= 6'd20) begin
            t = 4'd2; base = 6'd20;
        end else if (v >= 6'd10) begin
            t = 4'd1; base = 6'd10;
        end else begin
            t = 4'd0; base = 6'd0;
        end
        to_bcd = {t, 4'(v - base)};
    endfunction

    // ------------------------------------------------------------------
    // Input registers and edge detection
    // ------------------------------------------------------------------
    logic r_tick;
    logic r_mode, r_mode_prev;
    logic r_add,  r_add_prev;
    logic r_sub,  r_sub_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tick      <= 1'b0;
            r_mode      <= 1'b0;
            r_mode_prev <= 1'b0;
            r_add       <= 1'b0;
            r_add_prev  <= 1'b0;
            r_sub       <= 1'b0;
            r_sub_prev  <= 1'b0;
        end else begin
            r_tick      <= pulse_1hz;
            r_mode      <= mode_button;
            r_mode_prev <= r_mode;
            r_add       <= add_button;
            r_add_prev  <= r_add;
            r_sub       <= sub_button;
            r_sub_prev  <= r_sub;
        end
    end

    logic w_mode_rise, w_add_rise, w_sub_rise;
    assign w_mode_rise = r_mode & ~r_mode_prev;
    assign w_add_rise  = r_add  & ~r_add_prev;
    assign w_sub_rise  = r_sub  & ~r_sub_prev;

    // ------------------------------------------------------------------
    // Hold-to-repeat. The counter restarts at 1 on every step so that a
    // step fires when it equals the delay (first) or the period (after).
    // A repeat survives only while its own button is the only one held.
    // ------------------------------------------------------------------
    logic               r_rep_active;
    logic               r_rep_sub;
    logic               r_rep_first;
    logic [c_REP_W-1:0] r_rep_cnt;
    logic               w_rep_held;
    logic               w_rep_fire;

    assign w_rep_held = r_rep_active & (r_rep_sub ? (r_sub & ~r_add) : (r_add & ~r_sub));
    assign w_rep_fire = w_rep_held & ~w_add_rise & ~w_sub_rise &
                        (r_rep_cnt == (r_rep_first ? c_DELAY : c_PERIOD));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rep_active <= 1'b0;
            r_rep_sub    <= 1'b0;
            r_rep_first  <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (w_add_rise) begin
            r_rep_active <= 1'b1;
            r_rep_sub    <= 1'b0;
            r_rep_first  <= 1'b1;
            r_rep_cnt    <= c_REP_W'(1);
        end else if (w_sub_rise) begin
            r_rep_active <= 1'b1;
            r_rep_sub    <= 1'b1;
            r_rep_first  <= 1'b1;
            r_rep_cnt    <= c_REP_W'(1);
        end else if (!w_rep_held) begin
            r_rep_active <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (w_rep_fire) begin
            r_rep_first  <= 1'b0;
            r_rep_cnt    <= c_REP_W'(1);
        end else begin
            r_rep_cnt    <= r_rep_cnt + c_REP_W'(1);
        end
    end

    // Add wins when both rise together
    logic w_add_step, w_sub_step, w_btn_event;
    assign w_add_step  = w_add_rise | (w_rep_fire & ~r_rep_sub);
    assign w_sub_step  = (w_sub_rise & ~w_add_rise) | (w_rep_fire & r_rep_sub);
    assign w_btn_event = w_add_step | w_sub_step | w_mode_rise;

    // ------------------------------------------------------------------
    // FSM and idle timeout
    // ------------------------------------------------------------------
    state_t              r_state, w_state_next;
    logic [c_IDLE_W-1:0] r_idle;
    logic                w_timeout;

    assign w_timeout = c_TIMEOUT_EN && r_tick && (r_state != ST_RUN) &&
                       !w_btn_event && (r_idle == c_IDLE_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_mode_rise) begin
            case (r_state)
                ST_RUN:    w_state_next = ST_SET_H;
                ST_SET_H:  w_state_next = ST_SET_M;
                ST_SET_M:  w_state_next = ST_SET_S;
`ifdef WATCH_ALARM_EN
                ST_SET_S:  w_state_next = ST_SET_AH;
                ST_SET_AH: w_state_next = ST_SET_AM;
                ST_SET_AM: w_state_next = ST_RUN;
`else
                ST_SET_S:  w_state_next = ST_RUN;
`endif
                default:   w_state_next = ST_RUN;
            endcase
        end else if (w_timeout) begin
            w_state_next = ST_RUN;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idle <= '0;
        end else if ((r_state == ST_RUN) || w_btn_event || w_timeout) begin
            r_idle <= '0;
        end else if (r_tick && c_TIMEOUT_EN) begin
            r_idle <= r_idle + c_IDLE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Time registers
    // ------------------------------------------------------------------
    logic [4:0] r_hours;
    logic [5:0] r_minutes, r_seconds;
    logic [4:0] w_tick_hour;
    logic [5:0] w_tick_min, w_tick_sec;
    logic       w_sec_top, w_min_top;

    assign w_sec_top   = (r_seconds == 6'd59);
    assign w_min_top   = (r_minutes == 6'd59);
    assign w_tick_sec  = wrap_up(r_seconds, 6'd59);
    assign w_tick_min  = w_sec_top ? wrap_up(r_minutes, 6'd59) : r_minutes;
    assign w_tick_hour = (w_sec_top && w_min_top) ? 5'(wrap_up({1'b0, r_hours}, 6'd23)) : r_hours;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hours   <= '0;
            r_minutes <= '0;
            r_seconds <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (r_tick) begin
                        r_hours   <= w_tick_hour;
                        r_minutes <= w_tick_min;
                        r_seconds <= w_tick_sec;
                    end
                end
                ST_SET_H: begin
                    if (w_add_step)      r_hours <= 5'(wrap_up({1'b0, r_hours}, 6'd23));
                    else if (w_sub_step) r_hours <= 5'(wrap_dn({1'b0, r_hours}, 6'd23));
                end
                ST_SET_M: begin
                    if (w_add_step)      r_minutes <= wrap_up(r_minutes, 6'd59);
                    else if (w_sub_step) r_minutes <= wrap_dn(r_minutes, 6'd59);
                end
                ST_SET_S: begin
                    if (w_add_step)      r_seconds <= wrap_up(r_seconds, 6'd59);
                    else if (w_sub_step) r_seconds <= wrap_dn(r_seconds, 6'd59);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef WATCH_ALARM_EN
    // ------------------------------------------------------------------
    // Alarm
    // ------------------------------------------------------------------
    localparam int c_AL_W = (ALARM_SECONDS > 1) ? $clog2(ALARM_SECONDS + 1) : 1;

    logic [4:0]        r_alarm_hours;
    logic [5:0]        r_alarm_minutes;
    logic              r_armed_q;
    logic              r_alarm_out;
    logic [c_AL_W-1:0] r_alarm_cnt;
    logic              w_alarm_hit;
    logic              w_btn_edge;

    assign w_btn_edge  = w_mode_rise | w_add_rise | w_sub_rise;
    assign w_alarm_hit = (r_state == ST_RUN) && r_tick && alarm_armed &&
                         (w_tick_sec == 6'd0) && (w_tick_min == r_alarm_minutes) &&
                         (w_tick_hour == r_alarm_hours);
    assign alarm_out   = r_alarm_out;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_alarm_hours   <= '0;
            r_alarm_minutes <= '0;
        end else if (r_state == ST_SET_AH) begin
            if (w_add_step)      r_alarm_hours <= 5'(wrap_up({1'b0, r_alarm_hours}, 6'd23));
            else if (w_sub_step) r_alarm_hours <= 5'(wrap_dn({1'b0, r_alarm_hours}, 6'd23));
        end else if (r_state == ST_SET_AM) begin
            if (w_add_step)      r_alarm_minutes <= wrap_up(r_alarm_minutes, 6'd59);
            else if (w_sub_step) r_alarm_minutes <= wrap_dn(r_alarm_minutes, 6'd59);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_armed_q   <= 1'b0;
            r_alarm_out <= 1'b0;
            r_alarm_cnt <= '0;
        end else begin
            r_armed_q <= alarm_armed;
            if (w_btn_edge || (r_armed_q && !alarm_armed)) begin
                r_alarm_out <= 1'b0;
                r_alarm_cnt <= '0;
            end else if (w_alarm_hit) begin
                r_alarm_out <= 1'b1;
                r_alarm_cnt <= '0;
            end else if (r_alarm_out && r_tick) begin
                if (int'(r_alarm_cnt) + 1 >= ALARM_SECONDS) begin
                    r_alarm_out <= 1'b0;
                    r_alarm_cnt <= '0;
                end else begin
                    r_alarm_cnt <= r_alarm_cnt + c_AL_W'(1);
                end
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Display formatter
    // ------------------------------------------------------------------
    logic [4:0] w_disp_h, w_h12;
    logic [5:0] w_disp_m;
    logic       w_show_alarm, w_edit_h, w_edit_m, w_edit_s, w_pm;
    logic       w_sep_dp, w_sep3_dp, w_en_h, w_en_m, w_en_s;
    logic [7:0] w_h_bcd, w_m_bcd, w_s_bcd;
    logic [5:0] w_d1, w_d2, w_d3, w_d4, w_d5, w_d6, w_d7, w_d8;

    always_comb begin
        w_disp_h     = r_hours;
        w_disp_m     = r_minutes;
        w_show_alarm = 1'b0;
        w_edit_h     = (r_state == ST_SET_H);
        w_edit_m     = (r_state == ST_SET_M);
        w_edit_s     = (r_state == ST_SET_S);
        w_sep_dp     = (r_state == ST_RUN) ? ~pulse_500ms : 1'b1;
        w_sep3_dp    = w_sep_dp;
`ifdef WATCH_ALARM_EN
        if ((r_state == ST_SET_AH) || (r_state == ST_SET_AM)) begin
            w_show_alarm = 1'b1;
            w_disp_h     = r_alarm_hours;
            w_disp_m     = r_alarm_minutes;
        end
        if (r_state == ST_SET_AH) w_edit_h = 1'b1;
        if (r_state == ST_SET_AM) w_edit_m = 1'b1;
        if (alarm_armed)          w_sep3_dp = 1'b0;
`endif
        // 12-hour mapping: 0 -> 12, 13..23 -> value-12
        w_h12 = w_disp_h;
        if (mode_12h) begin
            if (w_disp_h == 5'd0)       w_h12 = 5'd12;
            else if (w_disp_h > 5'd12)  w_h12 = w_disp_h - 5'd12;
        end
        w_pm = mode_12h && (w_disp_h >= 5'd12);

        w_h_bcd = to_bcd({1'b0, w_h12});
        w_m_bcd = to_bcd(w_disp_m);
        w_s_bcd = to_bcd(r_seconds);

        w_en_h = w_edit_h ? pulse_500ms : 1'b1;
        w_en_m = w_edit_m ? pulse_500ms : 1'b1;
        w_en_s = w_edit_s ? pulse_500ms : 1'b1;

        w_d8 = {w_en_h, w_h_bcd[7:4], 1'b1};
        w_d7 = {w_en_h, w_h_bcd[3:0], 1'b1};
        w_d6 = {5'b00000, w_sep_dp};
        w_d5 = {w_en_m, w_m_bcd[7:4], 1'b1};
        w_d4 = {w_en_m, w_m_bcd[3:0], 1'b1};
        w_d3 = {5'b00000, w_sep3_dp};
        w_d2 = {w_en_s, w_s_bcd[7:4], 1'b1};
        w_d1 = {w_en_s, w_s_bcd[3:0], ~w_pm};
        if (w_show_alarm) begin
            w_d2 = 6'b000001;
            w_d1 = 6'b000001;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d8 <= 6'b100001;
            d7 <= 6'b100001;
            d6 <= 6'b000001;
            d5 <= 6'b100001;
            d4 <= 6'b100001;
            d3 <= 6'b000001;
            d2 <= 6'b100001;
            d1 <= 6'b100001;
        end else begin
            d8 <= w_d8;
            d7 <= w_d7;
            d6 <= w_d6;
            d5 <= w_d5;
            d4 <= w_d4;
            d3 <= w_d3;
            d2 <= w_d2;
            d1 <= w_d1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_watch_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_watch_core
//  Purpose  : Directed self-checking bench for watch_core (fast repeat and
//             timeout parameters). Alarm checks compile with WATCH_ALARM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_watch_core;

    logic clock = 1'b0;
    logic reset;
    logic pulse_1hz, pulse_500ms;
    logic mode_button, add_button, sub_button, mode_12h;
`ifdef WATCH_ALARM_EN
    logic alarm_armed, alarm_out;
`endif
    logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;

    int total = 0;
    int bad   = 0;

`ifdef WATCH_ALARM_EN
    localparam int c_MODES_TO_RUN = 3;  // from SET_SECONDS via both alarm states
`else
    localparam int c_MODES_TO_RUN = 1;
`endif

    watch_core #(
        .REPEAT_DELAY  (4),
        .REPEAT_PERIOD (2),
        .SET_TIMEOUT_S (3)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .pulse_1hz   (pulse_1hz),
        .pulse_500ms (pulse_500ms),
        .mode_button (mode_button),
        .add_button  (add_button),
        .sub_button  (sub_button),
        .mode_12h    (mode_12h),
`ifdef WATCH_ALARM_EN
        .alarm_armed (alarm_armed),
        .alarm_out   (alarm_out),
`endif
        .d1 (d1), .d2 (d2), .d3 (d3), .d4 (d4),
        .d5 (d5), .d6 (d6), .d7 (d7), .d8 (d8)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // btn: 0 mode, 1 add, 2 sub, 3 add+sub together
    task automatic press(input int btn);
        mode_button = (btn == 0);
        add_button  = (btn == 1) || (btn == 3);
        sub_button  = (btn == 2) || (btn == 3);
        cyc(1);
        mode_button = 1'b0;
        add_button  = 1'b0;
        sub_button  = 1'b0;
        cyc(3);
    endtask

    task automatic press_n(input int btn, input int n);
        for (int i = 0; i < n; i++) press(btn);
    endtask

    task automatic tick();
        pulse_1hz = 1'b1;
        cyc(1);
        pulse_1hz = 1'b0;
        cyc(3);
    endtask

    function automatic int dval(input logic [5:0] hi, input logic [5:0] lo);
        return int'(hi[4:1]) * 10 + int'(lo[4:1]);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_min;
        reset = 1'b1;
        pulse_1hz = 1'b0; pulse_500ms = 1'b1;
        mode_button = 1'b0; add_button = 1'b0; sub_button = 1'b0; mode_12h = 1'b0;
`ifdef WATCH_ALARM_EN
        alarm_armed = 1'b0;
`endif
        cyc(2);
        check("rst_digits", {d8, d7, d5, d4, d2, d1}, {6{6'b100001}});
        check("rst_seps", {d6, d3}, {6'b000001, 6'b000001});
`ifdef WATCH_ALARM_EN
        check("rst_alarm", alarm_out, 0);
`endif
        reset = 1'b0;
        cyc(2);
        check("run_sep", d6, 6'b000000);

        // Set 23:59:58 through the buttons
        press(0);
        check("set_sep", d6, 6'b000001);
        press(2);   check("hrs_sub_wrap", dval(d8, d7), 23);
        press(1);   check("hrs_add_wrap", dval(d8, d7), 0);
        press(2);   check("hrs_sub_again", dval(d8, d7), 23);
        press(3);   check("add_wins", dval(d8, d7), 0);
        press(2);
        press(0);
        press(2);   check("min_sub_wrap", dval(d5, d4), 59);
        press(0);
        press_n(2, 2);
        check("sec_set", dval(d2, d1), 58);
        press_n(0, c_MODES_TO_RUN);
        check("back_run", d6, 6'b000000);

        tick();
        check("tick_59", dval(d2, d1), 59);
        tick();
        check("rollover", {d8, d7, d5, d4, d2, d1}, {6{6'b100001}});

        // Hold add in SET_MINUTES from 58
        press(0); press(0);
        press_n(2, 2);
        check("min_58", dval(d5, d4), 58);
        add_button = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            cyc(1);
            if (k == 10) add_button = 1'b0;
            exp_min = (k < 3) ? 58 : (k < 7) ? 59 : (k < 9) ? 0 : (k < 11) ? 1 : 2;
            check($sformatf("repeat_k%0d", k), dval(d5, d4), exp_min);
        end

        // Idle timeout from SET_SECONDS
        press(0);
        tick(); tick();
        check("still_set", d6, 6'b000001);
        tick();
        check("timeout_run", d6, 6'b000000);
        check("timeout_sec", dval(d2, d1), 0);
        tick();
        check("run_again", dval(d2, d1), 1);

        // 12-hour display
        mode_12h = 1'b1;
        cyc(2);
        check("h12_zero", dval(d8, d7), 12);
        check("h12_am", d1[0], 1'b1);
        press(0);
        press_n(1, 13);
        check("h12_13", dval(d8, d7), 1);
        check("h12_pm", d1[0], 1'b0);
        pulse_500ms = 1'b0;
        cyc(2);
        check("blink", {d8[5], d7[5], d5[5]}, 3'b001);
        pulse_500ms = 1'b1;
        mode_12h = 1'b0;
        cyc(2);
        check("h24_13", dval(d8, d7), 13);
        press_n(0, 2 + c_MODES_TO_RUN);

        // Reset in the middle of set mode
        press(0);
        reset = 1'b1;
        #1;
        check("async_rst", {d7, d1}, {6'b100001, 6'b100001});
        cyc(2);
        reset = 1'b0;
        cyc(2);
        check("rst_to_run", d6, 6'b000000);

`ifdef WATCH_ALARM_EN
        press(0); press_n(1, 7);
        press(0); press_n(2, 31);
        press(0); press(2);
        press(0);
        check("alarm_blank", {d2, d1}, {6'b000001, 6'b000001});
        press_n(1, 7);
        check("alarm_hrs", dval(d8, d7), 7);
        press(0); press_n(1, 30);
        check("alarm_min", dval(d5, d4), 30);
        press(0);
        check("time_072959", dval(d8, d7) * 10000 + dval(d5, d4) * 100 + dval(d2, d1), 72959);
        alarm_armed = 1'b1;
        cyc(2);
        check("armed_dp", d3, 6'b000000);
        tick();
        check("alarm_fire", alarm_out, 1'b1);
        add_button = 1'b1;
        cyc(1);
        check("alarm_hold", alarm_out, 1'b1);
        add_button = 1'b0;
        cyc(1);
        check("alarm_clear", alarm_out, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
